wfid_retire_ctrl: RTL and testbench

- Return path of the wavefront-ID allocator.
- Collects end-of-program notifications per wavefront slot from issue and holds them in a pending bitmap.
- Serially releases each slot by driving the allocator's halt/WF_id_done pins, captures the 15-bit dispatcher tag returned for that slot, and reports the tag to the dispatcher over a valid/ack handshake.
- Sits between issue, wfid_generator and the dispatcher interface.

---
 rtl/wfid_retire_ctrl_pkg.sv | 24 ++
 rtl/wfid_prio_pick.sv | 25 ++
 rtl/wfid_retire_ctrl.sv | 125 ++++++++++++
 tb/tb_wfid_retire_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wfid_retire_ctrl_pkg.sv
// Shared sizes, FSM encoding and helpers for the wavefront-ID retire controller.
package wfid_retire_ctrl_pkg;

  localparam int unsigned WF_NUM = 40;
  localparam int unsigned WFID_W = 6;
  localparam int unsigned TAG_W  = 15;

  typedef enum logic [1:0] {
    RC_IDLE    = 2'd0,
    RC_RELEASE = 2'd1,
    RC_REPORT  = 2'd2
  } rc_state_e;

  // Number of set bits in a slot bitmap; 0..WF_NUM fits in WFID_W bits.
  function automatic logic [WFID_W-1:0] popcount_wf(input logic [WF_NUM-1:0] v);
    logic [WFID_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(WF_NUM); i++) begin
      c = c + WFID_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/wfid_prio_pick.sv
// Fixed-priority picker: lowest-index set bit of a slot bitmap.
module wfid_prio_pick
  import wfid_retire_ctrl_pkg::*;
#(
  parameter int unsigned N = WF_NUM,
  parameter int unsigned W = WFID_W
) (
  input  logic [N-1:0] bitmap_i,
  output logic [W-1:0] sel_id_o,
  output logic         any_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    sel_id_o = '0;
    any_o    = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (bitmap_i[i]) begin
        sel_id_o = W'(i);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wfid_retire_ctrl.sv
// Retire path of the wavefront-ID allocator: collects end-of-program
// notifications, releases slots one at a time and reports their tags.
module wfid_retire_ctrl
  import wfid_retire_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_done_valid,
  input  logic [WFID_W-1:0] issue_done_wfid,
  input  logic [WF_NUM-1:0] vacant,
  output logic              halt,
  output logic [WFID_W-1:0] WF_id_done,
  input  logic [TAG_W-1:0]  WF_tag_done,
  output logic              disp_done_valid,
  output logic [TAG_W-1:0]  disp_done_tag,
  input  logic              disp_done_ack,
  output logic [WFID_W-1:0] pending_cnt,
  output logic              err_dup
);

  // Index space reachable by a WFID_W-bit slot number (covers out-of-range ids).
  localparam int unsigned IDX_SPAN = 1 << WFID_W;

  rc_state_e         state_q;
  logic [WF_NUM-1:0] pending_q;
  logic [WF_NUM-1:0] pending_d;
  logic [WFID_W-1:0] cur_id_q;
  logic              halt_q;
  logic              disp_valid_q;
  logic [TAG_W-1:0]  disp_tag_q;
  logic [WFID_W-1:0] pending_cnt_q;
  logic              err_dup_q;

  logic [WFID_W-1:0]   sel_id;
  logic                any_pending;
  logic                busy;
  logic                cap_bad;
  logic [IDX_SPAN-1:0] vacant_ext;
  logic [IDX_SPAN-1:0] pending_ext;

  wfid_prio_pick #(
    .N (WF_NUM),
    .W (WFID_W)
  ) u_pick (
    .bitmap_i (pending_q),
    .sel_id_o (sel_id),
    .any_o    (any_pending)
  );

  assign busy        = (state_q != RC_IDLE);
  assign vacant_ext  = IDX_SPAN'(vacant);
  assign pending_ext = IDX_SPAN'(pending_q);

  // Capture validation and next pending bitmap; the release clear wins over a set.
  always_comb begin
    cap_bad   = 1'b0;
    pending_d = pending_q;
    if (issue_done_valid) begin
      cap_bad = (32'(issue_done_wfid) >= WF_NUM)
             || pending_ext[issue_done_wfid]
             || vacant_ext[issue_done_wfid]
             || (busy && (issue_done_wfid == cur_id_q));
      if (!cap_bad) begin
        pending_d[issue_done_wfid] = 1'b1;
      end
    end
    if (state_q == RC_RELEASE) begin
      pending_d[cur_id_q] = 1'b0;
    end
  end

  // Release/report sequencer with registered outputs, pending and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RC_IDLE;
      pending_q     <= '0;
      cur_id_q      <= '0;
      halt_q        <= 1'b0;
      disp_valid_q  <= 1'b0;
      disp_tag_q    <= '0;
      pending_cnt_q <= '0;
      err_dup_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      pending_cnt_q <= popcount_wf(pending_d);
      if (cap_bad) begin
        err_dup_q <= 1'b1;
      end
      case (state_q)
        RC_IDLE: begin
          if (any_pending) begin
            cur_id_q <= sel_id;
            halt_q   <= 1'b1;
            state_q  <= RC_RELEASE;
          end
        end
        RC_RELEASE: begin
          halt_q       <= 1'b0;
          disp_tag_q   <= WF_tag_done;
          disp_valid_q <= 1'b1;
          state_q      <= RC_REPORT;
        end
        RC_REPORT: begin
          if (disp_done_ack) begin
            disp_valid_q <= 1'b0;
            state_q      <= RC_IDLE;
          end
        end
        default: begin
          halt_q       <= 1'b0;
          disp_valid_q <= 1'b0;
          state_q      <= RC_IDLE;
        end
      endcase
    end
  end

  assign halt            = halt_q;
  assign WF_id_done      = cur_id_q;
  assign disp_done_valid = disp_valid_q;
  assign disp_done_tag   = disp_tag_q;
  assign pending_cnt     = pending_cnt_q;
  assign err_dup         = err_dup_q;

endmodule

// File: tb/tb_wfid_retire_ctrl.sv
// Self-checking bench for wfid_retire_ctrl: directed scenarios plus random traffic
// against a slot-set reference model.
module tb_wfid_retire_ctrl;
  import wfid_retire_ctrl_pkg::*;

  logic              clk;
  logic              rst;
  logic              issue_done_valid;
  logic [WFID_W-1:0] issue_done_wfid;
  logic [WF_NUM-1:0] vacant;
  logic              halt;
  logic [WFID_W-1:0] WF_id_done;
  logic [TAG_W-1:0]  WF_tag_done;
  logic              disp_done_valid;
  logic [TAG_W-1:0]  disp_done_tag;
  logic              disp_done_ack;
  logic [WFID_W-1:0] pending_cnt;
  logic              err_dup;

  int n_checks;
  int n_errors;

  // Reference model: set of pending slots, the slot in flight and its phase.
  bit          m_pend [WF_NUM];
  int          m_busy;
  bit          m_rel;
  bit          m_rep;
  logic [5:0]  m_last;
  logic [14:0] m_tag;
  bit          m_err;

  bit           prev_v;
  logic [14:0]  rep_q[$];
  logic [5:0]   halt_ids[$];

  wfid_retire_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .issue_done_valid (issue_done_valid),
    .issue_done_wfid  (issue_done_wfid),
    .vacant           (vacant),
    .halt             (halt),
    .WF_id_done       (WF_id_done),
    .WF_tag_done      (WF_tag_done),
    .disp_done_valid  (disp_done_valid),
    .disp_done_tag    (disp_done_tag),
    .disp_done_ack    (disp_done_ack),
    .pending_cnt      (pending_cnt),
    .err_dup          (err_dup)
  );

  // Allocator tag store stand-in: tag = 0x1A00 + slot.
  assign WF_tag_done = {9'h068, WF_id_done};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [14:0] tag_fn(input int id);
    return 15'h1A00 + 15'(id);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t obs=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_busy = -1;
    m_rel  = 1'b0;
    m_rep  = 1'b0;
    m_last = '0;
    m_tag  = '0;
    m_err  = 1'b0;
    prev_v = 1'b0;
  endtask

  function automatic int model_count();
    int c = 0;
    foreach (m_pend[i]) c += int'(m_pend[i]);
    return c;
  endfunction

  // One clock edge of the slot-level rules, using the inputs present at that edge.
  task automatic model_update();
    int  w;
    bit  ok;
    int  lo;
    if (rst) begin
      model_reset();
      return;
    end
    w  = int'(issue_done_wfid);
    ok = issue_done_valid && (w < int'(WF_NUM)) && !m_pend[w] && !vacant[w] && (m_busy != w);
    if (issue_done_valid && !ok) m_err = 1'b1;
    if (m_busy < 0) begin
      lo = -1;
      for (int i = int'(WF_NUM) - 1; i >= 0; i--) if (m_pend[i]) lo = i;
      if (lo >= 0) begin
        m_busy = lo;
        m_rel  = 1'b1;
        m_last = 6'(lo);
      end
    end else if (m_rel) begin
      m_pend[m_busy] = 1'b0;
      m_rel = 1'b0;
      m_rep = 1'b1;
      m_tag = tag_fn(m_busy);
    end else if (disp_done_ack) begin
      m_rep  = 1'b0;
      m_busy = -1;
    end
    if (ok) m_pend[w] = 1'b1;
  endtask

  task automatic compare_all();
    check_eq("halt",        32'(halt),            32'(m_rel));
    check_eq("wf_id_done",  32'(WF_id_done),      32'(m_last));
    check_eq("disp_valid",  32'(disp_done_valid), 32'(m_rep));
    check_eq("disp_tag",    32'(disp_done_tag),   32'(m_tag));
    check_eq("pending_cnt", 32'(pending_cnt),     32'(model_count()));
    check_eq("err_dup",     32'(err_dup),         32'(m_err));
  endtask

  // Advance one clock, update the model, then compare and log events.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    if (halt) halt_ids.push_back(WF_id_done);
    if (disp_done_valid && !prev_v) rep_q.push_back(disp_done_tag);
    prev_v = disp_done_valid;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cap(input int id);
    issue_done_valid = 1'b1;
    issue_done_wfid  = 6'(id);
  endtask

  task automatic nocap();
    issue_done_valid = 1'b0;
    issue_done_wfid  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nocap();
    vacant        = '0;
    disp_done_ack = 1'b0;
    steps(2);
    rst = 1'b0;
    model_reset();
    rep_q.delete();
    halt_ids.delete();
  endtask

  initial begin
    logic [14:0] held;
    int          k;
    int          n7;
    int          nrep;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    nocap();
    vacant        = '0;
    disp_done_ack = 1'b0;
    model_reset();
    #1;
    check_eq("rst_halt",  32'(halt),            32'd0);
    check_eq("rst_valid", 32'(disp_done_valid), 32'd0);
    check_eq("rst_cnt",   32'(pending_cnt),     32'd0);
    check_eq("rst_err",   32'(err_dup),         32'd0);
    check_eq("rst_tag",   32'(disp_done_tag),   32'd0);

    // Single release: halt one cycle after capture, report two cycles after.
    do_reset();
    cap(5);
    step();
    nocap();
    check_eq("s1_halt_early", 32'(halt), 32'd0);
    step();
    check_eq("s1_halt", 32'(halt), 32'd1);
    check_eq("s1_id",   32'(WF_id_done), 32'd5);
    step();
    check_eq("s1_halt_off", 32'(halt), 32'd0);
    check_eq("s1_valid", 32'(disp_done_valid), 32'd1);
    check_eq("s1_tag",   32'(disp_done_tag), 32'h1A05);
    disp_done_ack = 1'b1;
    step();
    disp_done_ack = 1'b0;
    check_eq("s1_done_valid", 32'(disp_done_valid), 32'd0);
    check_eq("s1_done_cnt",   32'(pending_cnt), 32'd0);

    // Three captures queued behind a busy report drain lowest-index first.
    do_reset();
    cap(30);
    step();
    nocap();
    steps(2);
    cap(12); step();
    cap(3);  step();
    cap(39); step();
    nocap();
    check_eq("s2_cnt_q", 32'(pending_cnt), 32'd3);
    for (int r = 0; r < 4; r++) begin
      k = 0;
      while (!disp_done_valid && k < 6) begin
        step();
        k++;
      end
      check_eq("s2_wait", 32'(disp_done_valid), 32'd1);
      check_eq("s2_cnt",  32'(pending_cnt), 32'(3 - r));
      held = disp_done_tag;
      for (int c = 0; c < 10; c++) begin
        step();
        check_eq("s2_hold", 32'(disp_done_tag), 32'(held));
      end
      disp_done_ack = 1'b1;
      step();
      disp_done_ack = 1'b0;
    end
    check_eq("s2_nrep", 32'(rep_q.size()), 32'd4);
    if (rep_q.size() == 4) begin
      check_eq("s2_ord0", 32'(rep_q[0]), 32'h1A1E);
      check_eq("s2_ord1", 32'(rep_q[1]), 32'h1A03);
      check_eq("s2_ord2", 32'(rep_q[2]), 32'h1A0C);
      check_eq("s2_ord3", 32'(rep_q[3]), 32'h1A27);
    end

    // Duplicate capture of a pending slot: sticky error, single release.
    do_reset();
    cap(7);
    step();
    cap(7);
    step();
    nocap();
    disp_done_ack = 1'b1;
    steps(6);
    disp_done_ack = 1'b0;
    n7 = 0;
    foreach (halt_ids[i]) if (halt_ids[i] == 6'd7) n7++;
    check_eq("s3_err",  32'(err_dup), 32'd1);
    check_eq("s3_n7",   32'(n7), 32'd1);
    steps(3);
    check_eq("s3_sticky", 32'(err_dup), 32'd1);

    // Vacant slot and out-of-range slot are rejected.
    do_reset();
    vacant[20] = 1'b1;
    cap(20);
    step();
    cap(45);
    step();
    nocap();
    vacant = '0;
    steps(5);
    check_eq("s4_nohalt", 32'(halt_ids.size()), 32'd0);
    check_eq("s4_err",    32'(err_dup), 32'd1);
    check_eq("s4_cnt",    32'(pending_cnt), 32'd0);

    // Capture landing in the release cycle of another slot.
    do_reset();
    disp_done_ack = 1'b1;
    cap(4);
    step();
    nocap();
    step();
    check_eq("s5_rel4", 32'(WF_id_done), 32'd4);
    cap(9);
    step();
    nocap();
    steps(8);
    disp_done_ack = 1'b0;
    check_eq("s5_nrep", 32'(rep_q.size()), 32'd2);
    if (rep_q.size() == 2) begin
      check_eq("s5_ord0", 32'(rep_q[0]), 32'h1A04);
      check_eq("s5_ord1", 32'(rep_q[1]), 32'h1A09);
    end
    check_eq("s5_err", 32'(err_dup), 32'd0);

    // Asynchronous reset in the middle of REPORT.
    do_reset();
    cap(11);
    step();
    cap(13);
    step();
    nocap();
    step();
    check_eq("s6a_pre", 32'(disp_done_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("s6a_valid", 32'(disp_done_valid), 32'd0);
    check_eq("s6a_halt",  32'(halt), 32'd0);
    check_eq("s6a_cnt",   32'(pending_cnt), 32'd0);
    model_reset();
    step();
    rst = 1'b0;
    nrep = rep_q.size();
    steps(6);
    check_eq("s6a_quiet", 32'(rep_q.size()), 32'(nrep));

    // Asynchronous reset in the middle of RELEASE.
    do_reset();
    cap(11);
    step();
    nocap();
    step();
    check_eq("s6b_pre", 32'(halt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("s6b_halt",  32'(halt), 32'd0);
    check_eq("s6b_valid", 32'(disp_done_valid), 32'd0);
    check_eq("s6b_cnt",   32'(pending_cnt), 32'd0);
    model_reset();
    step();
    rst = 1'b0;
    halt_ids.delete();
    nrep = rep_q.size();
    steps(6);
    check_eq("s6b_nohalt", 32'(halt_ids.size()), 32'd0);
    check_eq("s6b_quiet",  32'(rep_q.size()), 32'(nrep));

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 1) cap(int'($urandom_range(0, 47)));
      else nocap();
      vacant = '0;
      if ($urandom_range(0, 7) == 0) vacant[6'($urandom_range(0, 39))] = 1'b1;
      disp_done_ack = ($urandom_range(0, 2) != 0);
      step();
    end
    nocap();
    disp_done_ack = 1'b1;
    steps(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
